seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter N, default 8, operand and result width in bits (N >= 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  N  operand A, from the upstream operand register.
REQ-006 SHALL have port b  input  N  operand B, from the upstream operand register.
REQ-007 SHALL have port sel  input  4  operation code, from the upstream selector register.
REQ-008 SHALL have port result  output  N  registered result, held until the next completion.
REQ-009 SHALL have port flags  output  4  registered {N,Z,C,V}, bit3..bit0.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when result and flags update.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, ITER, DONE.
REQ-013 SHALL capture a, b and sel into internal registers at the edge where start=1 in IDLE; later input changes SHALL have no effect on the operation.
REQ-014 SHALL decode sel codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL (by b[2:0]), 6 SHR logical (by b[2:0]), 7 MUL, 8 DIV, 9 MOD.
REQ-015 SHALL go IDLE->EXEC for codes 0-6 and 10-15, and IDLE->ITER for codes 7-9.
REQ-016 SHALL go EXEC->DONE after one cycle, writing result and flags on that edge.
REQ-017 SHALL spend exactly N cycles in ITER (shift-add multiply, restoring divide), then write result and flags and go to DONE.
REQ-018 SHALL return DONE->IDLE unconditionally; done=1 only in DONE.
REQ-019 SHALL raise done 2 cycles after capture for single-cycle ops and N+1 cycles after capture for MUL/DIV/MOD.
REQ-020 SHALL drive busy=1 in EXEC and ITER, busy=0 in IDLE and DONE.
REQ-021 SHALL ignore start outside IDLE; no queueing.
REQ-022 SHALL compute flags as: N=result[N-1]; Z=(result==0).
REQ-023 SHALL compute C as: carry-out for ADD; borrow (a<b unsigned) for SUB; last bit shifted out for SHL/SHR; upper half of product nonzero for MUL; else 0.
REQ-024 SHALL compute V as: signed overflow for ADD/SUB; divide-by-zero for DIV/MOD; else 0.
REQ-025 SHALL give MUL the low N bits of the unsigned 2N-bit product, DIV the unsigned quotient and MOD the unsigned remainder.
REQ-026 SHALL still take N cycles in ITER when b=0 for DIV/MOD, returning result all-ones for DIV, result=a for MOD, and V=1.
REQ-027 SHALL give codes 10-15 result 0 and flags 4'b0100.

Reset
REQ-028 SHALL, on reset at any time including mid-ITER, force state IDLE, result=0, flags=0, busy=0, done=0, and clear the internal registers.
REQ-029 SHALL ignore start during reset and require a fresh start afterward.

Structure
REQ-030 SHALL define the op-code enum, FSM state enum and flag bit-index constants in shared package seq_alu_pkg.
REQ-031 SHALL place the iterative multiply/divide datapath in sub-module mul_div_iter (start, op, operands in; done, quotient/product, remainder out), instantiated once.
REQ-032 SHALL keep a single-cycle combinational datapath for codes 0-6 inside seq_alu.

Verification (N=8)
REQ-033 SHALL check ADD a=8'h7F, b=8'h01 -> result 8'h80, flags 4'b1001, done 2 cycles after capture, busy high 1 cycle.
REQ-034 SHALL check SUB a=8'h05, b=8'h07 -> result 8'hFE, flags 4'b1010.
REQ-035 SHALL check MUL 15*17 -> 8'hFF with C=0, and MUL 16*16 -> 8'h00 with flags 4'b0110; done 9 cycles after capture in both.
REQ-036 SHALL check DIV 200/7 -> 8'd28, MOD 200/7 -> 8'd4, and DIV 9/0 -> 8'hFF with V=1.
REQ-037 SHALL check that start pulses during a MUL are ignored, then that a new start is accepted the cycle after done.
REQ-038 SHALL check that reset asserted at ITER cycle 4 gives all outputs 0 immediately, state IDLE, and no done pulse afterward.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU: op codes, FSM states
// and flag bit positions.
package seq_alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_DIV = 4'd8,
    OP_MOD = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ITER,
    S_DONE
  } state_e;

  // Multi-cycle ops run through the iterative unit.
  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_mul_div_iter.sv
// Iterative N-step shift-add multiplier / restoring divider. Outputs are the
// next-step values so the caller can register the final step on the same edge.
module mul_div_iter
  import seq_alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [N-1:0]    a_i,
  input  logic [N-1:0]    b_i,
  output logic            done_c,
  output logic [N-1:0]    lo_c,
  output logic [N-1:0]    hi_c
);

  localparam int unsigned CW = $clog2(N) + 1;

  logic          active_q, active_d;
  logic          is_mul_q, is_mul_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  m_q, m_d;

  logic [N:0]    mul_sum;
  logic [N:0]    div_shift;
  logic [N+1:0]  div_diff;
  logic [N-1:0]  hi_step, lo_step;

  // One step: {hi,lo} is the product accumulator for MUL, {rem,quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : (N+1)'(0));
    div_shift = {hi_q, lo_q[N-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, m_q};
    if (is_mul_q) begin
      hi_step = mul_sum[N:1];
      lo_step = {mul_sum[0], lo_q[N-1:1]};
    end else if (!div_diff[N+1]) begin
      hi_step = div_diff[N-1:0];
      lo_step = {lo_q[N-2:0], 1'b1};
    end else begin
      hi_step = div_shift[N-1:0];
      lo_step = {lo_q[N-2:0], 1'b0};
    end
  end

  always_comb begin
    active_d = active_q;
    is_mul_d = is_mul_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    if (start_i) begin
      active_d = 1'b1;
      is_mul_d = (op_i == OP_MUL);
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = a_i;
      m_d      = b_i;
    end else if (active_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      is_mul_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
    end else begin
      active_q <= active_d;
      is_mul_q <= is_mul_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
    end
  end

  assign done_c = active_q && (cnt_q == CW'(N - 1));
  assign lo_c   = lo_step;
  assign hi_c   = hi_step;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops in EXEC, MUL/DIV/MOD through the iterative
// unit in ITER; result and flags are registered and held until the next op.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  input  logic [OP_W-1:0]   sel,
  output logic [N-1:0]      result,
  output logic [FLAG_W-1:0] flags,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [N-1:0]        a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [N-1:0]        result_q, result_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic [N:0]          add_ext, sub_ext, shl_ext, shr_ext;
  logic [2:0]          sh;
  logic [N-1:0]        alu_res;
  logic                alu_c, alu_v;

  logic                iter_start_c, iter_done_c;
  logic [N-1:0]        iter_lo, iter_hi;
  logic [N-1:0]        it_res;
  logic                it_c, it_v;

  assign iter_start_c = (state_q == S_IDLE) && start && is_iter_op(sel);

  mul_div_iter #(.N(N)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start_i (iter_start_c),
    .op_i    (sel),
    .a_i     (a),
    .b_i     (b),
    .done_c  (iter_done_c),
    .lo_c    (iter_lo),
    .hi_c    (iter_hi)
  );

  // Single-cycle datapath on the captured operands.
  always_comb begin
    sh      = b_q[2:0];
    add_ext = {1'b0, a_q} + {1'b0, b_q};
    sub_ext = {1'b0, a_q} - {1'b0, b_q};
    shl_ext = {1'b0, a_q} << sh;
    shr_ext = {a_q, 1'b0} >> sh;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = add_ext[N-1:0];
        alu_c   = add_ext[N];
        alu_v   = (a_q[N-1] == b_q[N-1]) && (add_ext[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        alu_res = sub_ext[N-1:0];
        alu_c   = sub_ext[N];
        alu_v   = (a_q[N-1] != b_q[N-1]) && (sub_ext[N-1] != a_q[N-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = shl_ext[N-1:0];
        alu_c   = shl_ext[N];
      end
      OP_SHR: begin
        alu_res = shr_ext[N:1];
        alu_c   = shr_ext[0];
      end
      default: ;
    endcase
  end

  // Final-step result selection for the iterative ops.
  always_comb begin
    it_res = iter_lo;
    it_c   = 1'b0;
    it_v   = 1'b0;
    case (op_q)
      OP_MUL: it_c = |iter_hi;
      OP_DIV: it_v = (b_q == '0);
      OP_MOD: begin
        it_res = iter_hi;
        it_v   = (b_q == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = sel;
          state_d = is_iter_op(sel) ? S_ITER : S_EXEC;
        end
      end
      S_EXEC: begin
        result_d        = alu_res;
        flags_d[FLAG_N] = alu_res[N-1];
        flags_d[FLAG_Z] = (alu_res == '0);
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_V] = alu_v;
        state_d         = S_DONE;
      end
      S_ITER: begin
        if (iter_done_c) begin
          result_d        = it_res;
          flags_d[FLAG_N] = it_res[N-1];
          flags_d[FLAG_Z] = (it_res == '0);
          flags_d[FLAG_C] = it_c;
          flags_d[FLAG_V] = it_v;
          state_d         = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_EXEC) || (state_d == S_ITER);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (N=8): single-cycle ops, MUL/DIV/MOD latency,
// start masking while busy, and reset in the middle of an iterative op.
module tb_seq_alu;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a, b;
  logic [3:0] sel;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  seq_alu #(.N(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .sel    (sel),
    .result (result),
    .flags  (flags),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for done; cyc counts edges from capture.
  task automatic run_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                        output int cyc, output int bcnt);
    @(negedge clk);
    sel = op; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; sel = 4'd1;
    cyc = 1; bcnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; sel = '0;
    repeat (2) @(negedge clk);
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    int cyc, bc;
    run_op(4'd0, 8'h7F, 8'h01, cyc, bc);
    checks++; if (result !== 8'h80) begin errors++; $display("FAIL add_result got %h exp 80", result); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL add_flags got %b exp 1001", flags); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL add_latency got %0d exp 2", cyc); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL add_busy_cycles got %0d exp 1", bc); end
    run_op(4'd0, 8'hFF, 8'h01, cyc, bc);
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL add_carry_result got %h exp 00", result); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL add_carry_flags got %b exp 0110", flags); end
  endtask

  task automatic test_sub();
    int cyc, bc;
    run_op(4'd1, 8'h05, 8'h07, cyc, bc);
    checks++; if (result !== 8'hFE) begin errors++; $display("FAIL sub_result got %h exp FE", result); end
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL sub_flags got %b exp 1010", flags); end
    run_op(4'd1, 8'h80, 8'h01, cyc, bc);
    checks++; if (result !== 8'h7F) begin errors++; $display("FAIL sub_ovf_result got %h exp 7F", result); end
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL sub_ovf_flags got %b exp 0001", flags); end
  endtask

  task automatic test_logic_shift();
    int cyc, bc;
    run_op(4'd2, 8'hF0, 8'h3C, cyc, bc);
    checks++; if ({result, flags} !== {8'h30, 4'b0000}) begin errors++; $display("FAIL and got %h/%b exp 30/0000", result, flags); end
    run_op(4'd3, 8'h0F, 8'hF0, cyc, bc);
    checks++; if ({result, flags} !== {8'hFF, 4'b1000}) begin errors++; $display("FAIL or got %h/%b exp FF/1000", result, flags); end
    run_op(4'd4, 8'hAA, 8'hAA, cyc, bc);
    checks++; if ({result, flags} !== {8'h00, 4'b0100}) begin errors++; $display("FAIL xor got %h/%b exp 00/0100", result, flags); end
    run_op(4'd5, 8'h81, 8'h09, cyc, bc);
    checks++; if ({result, flags} !== {8'h02, 4'b0010}) begin errors++; $display("FAIL shl got %h/%b exp 02/0010", result, flags); end
    run_op(4'd6, 8'h81, 8'h01, cyc, bc);
    checks++; if ({result, flags} !== {8'h40, 4'b0010}) begin errors++; $display("FAIL shr got %h/%b exp 40/0010", result, flags); end
    run_op(4'd6, 8'h81, 8'h00, cyc, bc);
    checks++; if ({result, flags} !== {8'h81, 4'b1000}) begin errors++; $display("FAIL shr0 got %h/%b exp 81/1000", result, flags); end
    run_op(4'd12, 8'h12, 8'h34, cyc, bc);
    checks++; if ({result, flags} !== {8'h00, 4'b0100}) begin errors++; $display("FAIL undef_op got %h/%b exp 00/0100", result, flags); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL undef_latency got %0d exp 2", cyc); end
  endtask

  task automatic test_mul();
    int cyc, bc;
    run_op(4'd7, 8'd15, 8'd17, cyc, bc);
    checks++; if ({result, flags} !== {8'hFF, 4'b1000}) begin errors++; $display("FAIL mul_15x17 got %h/%b exp FF/1000", result, flags); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL mul_latency got %0d exp 9", cyc); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 8", bc); end
    run_op(4'd7, 8'd16, 8'd16, cyc, bc);
    checks++; if ({result, flags} !== {8'h00, 4'b0110}) begin errors++; $display("FAIL mul_16x16 got %h/%b exp 00/0110", result, flags); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL mul2_latency got %0d exp 9", cyc); end
    run_op(4'd7, 8'd13, 8'd11, cyc, bc);
    checks++; if ({result, flags} !== {8'h8F, 4'b1000}) begin errors++; $display("FAIL mul_13x11 got %h/%b exp 8F/1000", result, flags); end
  endtask

  task automatic test_div();
    int cyc, bc;
    run_op(4'd8, 8'd200, 8'd7, cyc, bc);
    checks++; if ({result, flags} !== {8'd28, 4'b0000}) begin errors++; $display("FAIL div_200_7 got %h/%b exp 1c/0000", result, flags); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL div_latency got %0d exp 9", cyc); end
    run_op(4'd9, 8'd200, 8'd7, cyc, bc);
    checks++; if ({result, flags} !== {8'd4, 4'b0000}) begin errors++; $display("FAIL mod_200_7 got %h/%b exp 04/0000", result, flags); end
    run_op(4'd8, 8'd9, 8'd0, cyc, bc);
    checks++; if ({result, flags} !== {8'hFF, 4'b1001}) begin errors++; $display("FAIL div_by_zero got %h/%b exp FF/1001", result, flags); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL div0_latency got %0d exp 9", cyc); end
    run_op(4'd9, 8'd9, 8'd0, cyc, bc);
    checks++; if ({result, flags} !== {8'h09, 4'b0001}) begin errors++; $display("FAIL mod_by_zero got %h/%b exp 09/0001", result, flags); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    @(negedge clk);
    sel = 4'd7; a = 8'd15; b = 8'd17; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    // Hammer start with an ADD while the multiply is running.
    while (done !== 1'b1 && cyc < 40) begin
      start = (cyc >= 2 && cyc <= 7); sel = 4'd0; a = 8'd1; b = 8'd1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL b2b_mul_latency got %0d exp 9", cyc); end
    checks++; if (result !== 8'hFF) begin errors++; $display("FAIL b2b_mul_result got %h exp FF", result); end
    run_op(4'd0, 8'd1, 8'd2, cyc, bc);
    checks++; if (result !== 8'h03) begin errors++; $display("FAIL b2b_add_result got %h exp 03", result); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL b2b_add_latency got %0d exp 2", cyc); end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", {busy, done}); end
  endtask

  task automatic test_reset_mid_iter();
    int seen_done, seen_busy;
    @(negedge clk);
    sel = 4'd7; a = 8'd15; b = 8'd17; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL iter_busy_before_reset got %b exp 1", busy); end
    #2;
    reset = 1'b1; start = 1'b1; sel = 4'd0; a = 8'd3; b = 8'd4;
    #1;
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL midrst_result got %h exp 00", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL midrst_flags got %b exp 0000", flags); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrst_busy_done got %b exp 00", {busy, done}); end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0; seen_busy = 0;
    repeat (15) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done++;
      if (busy !== 1'b0) seen_busy++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", seen_done); end
    checks++; if (seen_busy !== 0) begin errors++; $display("FAIL midrst_idle got %0d exp 0", seen_busy); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL midrst_result_hold got %h exp 00", result); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_iter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
